reorder_buffer_p: RTL and testbench

Parametrised reorder buffer for the out-of-order core. It allocates one tagged entry per cycle from the rename stage and accepts `WB_PORTS` ALU results per cycle in any order. It retires up to `COMMIT_W` completed entries per cycle, in program order, to the register file and RAT. It adds source-operand lookup with writeback bypass and selective flush of younger entries on mispredict, which the current two-port ROB lacks.

---
 rtl/reorder_buffer_p.sv | 186 ++++++++++++++++++
 tb/tb_reorder_buffer_p.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_p.sv
// Reorder buffer: in-order allocation from rename, out-of-order writeback from
// WB_PORTS ALUs, and in-order retirement of up to COMMIT_W entries per cycle.
// It also provides source-operand lookup with writeback bypass and a selective
// flush that squashes every entry younger than a given tag.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   alloc_valid/dest           rename request and its destination register
//   alloc_ready/tag            room available (no flush) / tag handed out
//   wb_valid/tag/value         per-port writeback, port i in slice i
//   src_tag -> src_done/value  two operand lookups, bypassing this cycle's writebacks
//   flush_valid/tag            squash entries strictly younger than flush_tag
//   commit_valid/dest/value/tag  retirement slots; valid is a run of ones from bit 0
//   count                      occupied entries
module reorder_buffer_p #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned COMMIT_W = 2,
  localparam int unsigned TAG_W   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [REG_W-1:0]             alloc_dest,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
  input  logic [2*TAG_W-1:0]           src_tag,
  output logic [1:0]                   src_done,
  output logic [2*DATA_W-1:0]          src_value,
  input  logic                         flush_valid,
  input  logic [TAG_W-1:0]             flush_tag,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*REG_W-1:0]    commit_dest,
  output logic [COMMIT_W*DATA_W-1:0]   commit_value,
  output logic [COMMIT_W*TAG_W-1:0]    commit_tag,
  output logic [TAG_W:0]               count
);

  localparam int unsigned PTR_W = TAG_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [REG_W-1:0]  dest_d [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]  n_commit;
  logic              alloc_fire;

  // Wrap bit in the MSB makes full and empty distinguishable.
  assign count       = tail_q - head_q;
  assign alloc_ready = (count < PTR_W'(DEPTH)) && !flush_valid;
  assign alloc_tag   = tail_q[TAG_W-1:0];
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Commit slots: a running AND from head keeps commit_valid contiguous.
  // Entries outside [head, tail) are always invalid, so the run stops at tail.
  always_comb begin
    logic             run;
    logic [TAG_W-1:0] idx;
    run          = 1'b1;
    idx          = '0;
    n_commit     = '0;
    commit_valid = '0;
    commit_dest  = '0;
    commit_value = '0;
    commit_tag   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx = head_q[TAG_W-1:0] + TAG_W'(k);
      run = run && valid_q[idx] && done_q[idx];
      commit_tag[k*TAG_W +: TAG_W] = idx;
      if (run) begin
        commit_valid[k]                = 1'b1;
        commit_dest[k*REG_W +: REG_W]  = dest_q[idx];
        commit_value[k*DATA_W +: DATA_W] = value_q[idx];
        n_commit                       = n_commit + PTR_W'(1);
      end
    end
  end

  // Operand lookup; ports scanned high to low so the lowest port wins.
  always_comb begin
    logic [TAG_W-1:0] st;
    st        = '0;
    src_done  = '0;
    src_value = '0;
    for (int j = 0; j < 2; j++) begin
      st          = src_tag[j*TAG_W +: TAG_W];
      src_done[j] = valid_q[st] && done_q[st];
      src_value[j*DATA_W +: DATA_W] = value_q[st];
      for (int i = WB_PORTS - 1; i >= 0; i--) begin
        if (wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == st)) begin
          src_done[j] = 1'b1;
          src_value[j*DATA_W +: DATA_W] = wb_value[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next state. Order of application: writeback, commit clear, flush squash,
  // allocation, so a squash overrides a same-cycle writeback.
  always_comb begin
    logic [TAG_W-1:0] t;
    logic [TAG_W-1:0] f_off;
    logic [TAG_W-1:0] off;
    logic [PTR_W-1:0] keep;
    t       = '0;
    f_off   = '0;
    off     = '0;
    keep    = '0;
    valid_d = valid_q;
    done_d  = done_q;
    dest_d  = dest_q;
    value_d = value_q;
    head_d  = head_q + n_commit;
    tail_d  = tail_q;

    for (int i = WB_PORTS - 1; i >= 0; i--) begin
      t = wb_tag[i*TAG_W +: TAG_W];
      if (wb_valid[i] && valid_q[t]) begin
        done_d[t]  = 1'b1;
        value_d[t] = wb_value[i*DATA_W +: DATA_W];
      end
    end

    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_valid[k]) begin
        t          = head_q[TAG_W-1:0] + TAG_W'(k);
        valid_d[t] = 1'b0;
        done_d[t]  = 1'b0;
      end
    end

    if (flush_valid) begin
      // Age is the distance from head; anything older than flush_tag survives.
      f_off = flush_tag - head_q[TAG_W-1:0];
      for (int e = 0; e < DEPTH; e++) begin
        off = TAG_W'(e) - head_q[TAG_W-1:0];
        if (off > f_off) begin
          valid_d[e] = 1'b0;
          done_d[e]  = 1'b0;
        end
      end
      // Tail is rebuilt from head so the wrap bit stays consistent; never let
      // it fall behind a head that retired past the survivors.
      keep   = PTR_W'(f_off) + PTR_W'(1);
      tail_d = head_q + ((n_commit > keep) ? n_commit : keep);
    end

    if (alloc_fire) begin
      t          = tail_q[TAG_W-1:0];
      valid_d[t] = 1'b1;
      done_d[t]  = 1'b0;
      dest_d[t]  = alloc_dest;
      value_d[t] = '0;
      tail_d     = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        dest_q[e]  <= '0;
        value_q[e] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      dest_q  <= dest_d;
      value_q <= value_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer_p.sv
// Bench for reorder_buffer_p: a program-order queue model plus a negedge
// monitor that compares every output each cycle and then advances the model.
module tb_reorder_buffer_p;

  localparam int DEPTH    = 16;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int WB_PORTS = 2;
  localparam int COMMIT_W = 2;
  localparam int TAG_W    = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        alloc_valid;
  logic [REG_W-1:0]            alloc_dest;
  logic                        alloc_ready;
  logic [TAG_W-1:0]            alloc_tag;
  logic [WB_PORTS-1:0]         wb_valid;
  logic [WB_PORTS*TAG_W-1:0]   wb_tag;
  logic [WB_PORTS*DATA_W-1:0]  wb_value;
  logic [2*TAG_W-1:0]          src_tag;
  logic [1:0]                  src_done;
  logic [2*DATA_W-1:0]         src_value;
  logic                        flush_valid;
  logic [TAG_W-1:0]            flush_tag;
  logic [COMMIT_W-1:0]         commit_valid;
  logic [COMMIT_W*REG_W-1:0]   commit_dest;
  logic [COMMIT_W*DATA_W-1:0]  commit_value;
  logic [COMMIT_W*TAG_W-1:0]   commit_tag;
  logic [TAG_W:0]              count;

  reorder_buffer_p #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W),
    .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .src_tag(src_tag), .src_done(src_done), .src_value(src_value),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                tag;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
    bit                done;
  } ent_t;

  ent_t rob_q[$];     // live entries, oldest first
  int   next_tag = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_tag(input int tag);
    foreach (rob_q[e]) if (rob_q[e].tag == tag) return e;
    return -1;
  endfunction

  // Oldest entries already complete, capped at the retire width.
  function automatic int lead_done();
    int n = 0;
    while (n < COMMIT_W && n < rob_q.size() && rob_q[n].done) n++;
    return n;
  endfunction

  // Monitor: compare against the model, then apply this cycle's inputs to it.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_count", count, 0);
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_tag", alloc_tag, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_src_done", src_done, 0);
      rob_q.delete();
      next_tag = 0;
    end else begin
      int n, pre_size, idx;
      bit hit, exp_done;
      logic [DATA_W-1:0] exp_val;
      n        = lead_done();
      pre_size = rob_q.size();
      chk("count", count, pre_size);
      chk("alloc_ready", alloc_ready, (pre_size < DEPTH) && !flush_valid);
      chk("alloc_tag", alloc_tag, next_tag);
      for (int k = 0; k < COMMIT_W; k++) begin
        chk("commit_valid", commit_valid[k], k < n);
        if (k < n) begin
          chk("commit_tag", commit_tag[k*TAG_W +: TAG_W], rob_q[k].tag);
          chk("commit_dest", commit_dest[k*REG_W +: REG_W], rob_q[k].dest);
          chk("commit_value", commit_value[k*DATA_W +: DATA_W], rob_q[k].value);
        end
      end
      for (int j = 0; j < 2; j++) begin
        hit     = 0;
        exp_val = '0;
        for (int i = WB_PORTS - 1; i >= 0; i--)
          if (wb_valid[i] && wb_tag[i*TAG_W +: TAG_W] == src_tag[j*TAG_W +: TAG_W]) begin
            hit     = 1;
            exp_val = wb_value[i*DATA_W +: DATA_W];
          end
        exp_done = hit;
        idx = find_tag(int'(src_tag[j*TAG_W +: TAG_W]));
        if (!hit && idx >= 0 && rob_q[idx].done) begin
          exp_done = 1;
          exp_val  = rob_q[idx].value;
        end
        chk("src_done", src_done[j], exp_done);
        if (exp_done) chk("src_value", src_value[j*DATA_W +: DATA_W], exp_val);
      end
      // Writebacks: lowest port applied last so it wins.
      for (int i = WB_PORTS - 1; i >= 0; i--)
        if (wb_valid[i]) begin
          idx = find_tag(int'(wb_tag[i*TAG_W +: TAG_W]));
          if (idx >= 0) begin
            rob_q[idx].done  = 1;
            rob_q[idx].value = wb_value[i*DATA_W +: DATA_W];
          end
        end
      if (flush_valid) begin
        idx = find_tag(int'(flush_tag));
        if (idx >= 0) while (rob_q.size() > idx + 1) void'(rob_q.pop_back());
        next_tag = (int'(flush_tag) + 1) % DEPTH;
      end
      for (int k = 0; k < n; k++) if (rob_q.size() > 0) void'(rob_q.pop_front());
      if (alloc_valid && pre_size < DEPTH && !flush_valid) begin
        rob_q.push_back('{tag: next_tag, dest: alloc_dest, value: '0, done: 0});
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  end

  task automatic idle();
    alloc_valid = 0;
    alloc_dest  = '0;
    wb_valid    = '0;
    wb_tag      = '0;
    wb_value    = '0;
    src_tag     = '0;
    flush_valid = 0;
    flush_tag   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [DATA_W-1:0] val);
    wb_valid[p]                  = 1'b1;
    wb_tag[p*TAG_W +: TAG_W]     = TAG_W'(tag);
    wb_value[p*DATA_W +: DATA_W] = val;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      alloc_valid = 1;
      alloc_dest  = REG_W'(i + 3);
      step();
    end
    idle();
  endtask

  // Complete every outstanding entry and wait for the buffer to empty.
  task automatic drain();
    for (int c = 0; c < 200 && rob_q.size() > 0; c++) begin
      int p = 0;
      idle();
      foreach (rob_q[e])
        if (!rob_q[e].done && p < WB_PORTS) begin
          set_wb(p, rob_q[e].tag, $urandom);
          p++;
        end
      step();
    end
    idle();
    @(negedge clk);
    chk("drain_empty", count, 0);
    step();
  endtask

  initial begin
    rst = 0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    step();

    // Fill: the 17th request is refused and tail stays put.
    for (int i = 0; i < 17; i++) begin
      idle();
      alloc_valid = 1;
      alloc_dest  = REG_W'(i);
      step();
    end
    idle();
    @(negedge clk);
    chk("fill_count", count, 16);
    chk("fill_ready", alloc_ready, 0);
    chk("fill_tail", alloc_tag, 0);
    step();
    drain();

    // Out-of-order writeback 3,2,1,0 then paired retirement.
    do_reset();
    alloc_n(4);
    for (int t = 3; t >= 0; t--) begin
      idle();
      set_wb(0, t, DATA_W'(100 + t));
      @(negedge clk);
      chk("ooo_no_commit", commit_valid, 0);
      step();
    end
    idle();
    @(negedge clk);
    chk("ooo_first_pair", commit_valid, 2'b11);
    chk("ooo_slot0_tag", commit_tag[TAG_W-1:0], 0);
    chk("ooo_slot1_value", commit_value[2*DATA_W-1:DATA_W], 101);
    step();
    @(negedge clk);
    chk("ooo_second_pair", commit_valid, 2'b11);
    chk("ooo_slot0_tag2", commit_tag[TAG_W-1:0], 2);
    chk("ooo_slot1_value2", commit_value[2*DATA_W-1:DATA_W], 103);
    step();
    drain();

    // Dual writeback to one tag with bypass.
    do_reset();
    alloc_n(6);
    set_wb(0, 5, 32'hAA);
    set_wb(1, 5, 32'hBB);
    src_tag[TAG_W-1:0] = 4'd5;
    @(negedge clk);
    chk("bypass_done", src_done[0], 1);
    chk("bypass_value", src_value[DATA_W-1:0], 32'hAA);
    step();
    idle();
    src_tag[2*TAG_W-1:TAG_W] = 4'd5;
    @(negedge clk);
    chk("stored_value", src_value[2*DATA_W-1:DATA_W], 32'hAA);
    step();
    drain();

    // Flush at tag 3 while port 0 writes squashed tag 6.
    do_reset();
    alloc_n(8);
    flush_valid = 1;
    flush_tag   = 4'd3;
    alloc_valid = 1;
    set_wb(0, 6, 32'h66);
    @(negedge clk);
    chk("flush_refuse", alloc_ready, 0);
    step();
    idle();
    @(negedge clk);
    chk("flush_count", count, 4);
    chk("flush_next_tag", alloc_tag, 4);
    step();
    drain();

    // Wrap: 40 allocate/retire pairs.
    for (int i = 0; i < 40; i++) begin
      idle();
      alloc_valid = 1;
      alloc_dest  = REG_W'($urandom);
      if (rob_q.size() > 0 && !rob_q[rob_q.size()-1].done)
        set_wb(0, rob_q[rob_q.size()-1].tag, $urandom);
      step();
    end
    drain();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      int n, f;
      idle();
      n = lead_done();
      alloc_valid = ($urandom_range(99) < 60);
      alloc_dest  = REG_W'($urandom);
      if (rob_q.size() > 0) begin
        for (int p = 0; p < WB_PORTS; p++)
          if ($urandom_range(99) < 45)
            set_wb(p, rob_q[$urandom_range(rob_q.size()-1)].tag, $urandom);
        if ($urandom_range(99) < 4) begin
          f = $urandom_range(rob_q.size() - 1, (n > 0) ? n - 1 : 0);
          flush_valid = 1;
          flush_tag   = TAG_W'(rob_q[f].tag);
        end
      end
      src_tag = 8'($urandom);
      step();
    end
    drain();

    // Reset mid-operation.
    alloc_n(6);
    rst = 0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_commit", commit_valid, 0);
    chk("midrst_tag", alloc_tag, 0);
    step();
    rst = 1;
    alloc_valid = 1;
    @(negedge clk);
    chk("post_rst_tag", alloc_tag, 0);
    step();
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
